// File: rtl/temp_sensor_if.sv
// temp_sensor_if: serial front-end for the home temperature sensor.
// Drives cs_n/sclk, shifts in an 8-bit reading plus a parity bit once per
// sampling period, and publishes the reading clamped to 0..31 degC.
// Optional feature: define TEMP_AVG_EN to publish a 4-sample running average
// instead of the latest clamped value.
module temp_sensor_if #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_sdo,
    output logic       sensor_cs_n,
    output logic       sensor_sclk,
    output logic [4:0] temperature,
    output logic       temp_valid,
    output logic       temp_ready,
    output logic       temp_err
);

    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic [PW-1:0]   period_cnt;
    logic [DW-1:0]   div_cnt;
    logic [4:0]      edge_cnt;
    logic [8:0]      shreg;
    logic            tick;
    logic            div_last;
    logic            frame_good;
    logic [4:0]      clamped;
    logic [4:0]      new_temp;

    // Saturate the raw 8-bit reading into the 0..31 range the AC block accepts.
    function automatic logic [4:0] clamp_temp(input logic [7:0] raw);
        return (raw > 8'd31) ? 5'd31 : raw[4:0];
    endfunction

    assign tick       = (period_cnt == PW'(SAMPLE_PERIOD - 1));
    assign div_last   = (div_cnt == DW'(CLK_DIV - 1));
    assign frame_good = ~^shreg;
    assign clamped    = clamp_temp(shreg[8:1]);

    // Free-running sampling period counter; wraps regardless of FSM state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_cnt <= '0;
        end else if (tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; ticks outside IDLE are simply ignored.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (tick) next_state = SETUP;
            SETUP:   if (div_last) next_state = SHIFT;
            SHIFT:   if (div_last && (edge_cnt == 5'd17)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Serial bus timing: cs_n, sclk divider and sclk edge count, all glitch-free registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sensor_cs_n <= 1'b1;
            sensor_sclk <= 1'b0;
            div_cnt     <= '0;
            edge_cnt    <= '0;
        end else begin
            sensor_cs_n <= !((next_state == SETUP) || (next_state == SHIFT));
            if ((state == SETUP) || (state == SHIFT)) begin
                div_cnt <= div_last ? '0 : div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
            end
            if (state == SHIFT) begin
                if (div_last) begin
                    sensor_sclk <= ~sensor_sclk;
                    edge_cnt    <= edge_cnt + 5'd1;
                end
            end else begin
                sensor_sclk <= 1'b0;
                edge_cnt    <= '0;
            end
        end
    end

    // Capture sdo on the cycle sclk rises; after 9 bits shreg = {raw[7:0], parity}.
    always_ff @(posedge clk) begin
        if ((state == SHIFT) && div_last && !sensor_sclk) begin
            shreg <= {shreg[7:0], sensor_sdo};
        end
    end

`ifdef TEMP_AVG_EN
    logic [4:0] hist      [4];
    logic [4:0] hist_next [4];
    logic [6:0] hist_sum;

    // Candidate history for a good frame: the first good sample fills every entry.
    always_comb begin
        if (!temp_ready) begin
            for (int i = 0; i < 4; i++) hist_next[i] = clamped;
        end else begin
            hist_next[0] = clamped;
            for (int i = 1; i < 4; i++) hist_next[i] = hist[i-1];
        end
        hist_sum = {2'b00, hist_next[0]} + {2'b00, hist_next[1]} +
                   {2'b00, hist_next[2]} + {2'b00, hist_next[3]};
    end

    assign new_temp = hist_sum[6:2];

    // History only advances on good frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
        end else if ((state == DONE) && frame_good) begin
            for (int i = 0; i < 4; i++) hist[i] <= hist_next[i];
        end
    end
`else
    assign new_temp = clamped;
`endif

    // Publish the frame result on the edge that ends DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            temperature <= '0;
            temp_valid  <= 1'b0;
            temp_ready  <= 1'b0;
            temp_err    <= 1'b0;
        end else begin
            temp_valid <= 1'b0;
            temp_err   <= 1'b0;
            if (state == DONE) begin
                if (frame_good) begin
                    temperature <= new_temp;
                    temp_valid  <= 1'b1;
                    temp_ready  <= 1'b1;
                end else begin
                    temp_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_temp_sensor_if.sv
// Testbench for temp_sensor_if with a sensor model that shifts on sclk falling edges.
module tb_temp_sensor_if;

    localparam int CLK_DIV       = 2;
    localparam int SAMPLE_PERIOD = 64;
    localparam int BUDGET        = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sensor_sdo;
    logic       sensor_cs_n;
    logic       sensor_sclk;
    logic [4:0] temperature;
    logic       temp_valid;
    logic       temp_ready;
    logic       temp_err;

    typedef struct packed {
        logic       valid;
        logic       err;
        logic [4:0] temp;
        logic       ready;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [8:0] frame = 9'd0;
    logic [3:0] falls = 4'd0;
    logic [3:0] rises = 4'd0;

    temp_sensor_if #(
        .CLK_DIV      (CLK_DIV),
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sensor_sdo (sensor_sdo),
        .sensor_cs_n(sensor_cs_n),
        .sensor_sclk(sensor_sclk),
        .temperature(temperature),
        .temp_valid (temp_valid),
        .temp_ready (temp_ready),
        .temp_err   (temp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sensor: MSB presented while cs_n is high, next bit after each sclk fall.
    always @(negedge sensor_sclk or posedge sensor_cs_n) begin
        if (sensor_cs_n) falls <= 4'd0;
        else             falls <= falls + 4'd1;
    end

    assign sensor_sdo = (falls < 4'd9) ? frame[4'd8 - falls] : 1'b0;

    // Count sclk rising edges inside each chip-select window.
    always @(posedge sensor_sclk or negedge sensor_cs_n) begin
        if (!sensor_sclk)     rises <= 4'd0;
        else if (!sensor_cs_n) rises <= rises + 4'd1;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        rst = 1'b1;
    endtask

    task automatic queue_frame(input logic [8:0] f, input exp_t e);
        frame = f;
        exp_q.push_back(e);
    endtask

    task automatic wait_output(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (temp_valid || temp_err) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cs(input logic level, output bit seen, output int t);
        seen = 1'b0;
        t    = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (sensor_cs_n == level) begin
                seen = 1'b1;
                t    = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({sensor_cs_n, sensor_sclk, temperature, temp_valid, temp_ready, temp_err} !== 10'b10_00000_000) begin
            bad++;
            $display("FAIL reset_values: got cs_n=%b sclk=%b temp=%0d valid=%b ready=%b err=%b, want 1 0 0 0 0 0",
                     sensor_cs_n, sensor_sclk, temperature, temp_valid, temp_ready, temp_err);
        end
        rst = 1'b1;
    endtask

    task automatic test_good_frame();
        bit   ok_f, ok_r, seen;
        int   t_fall, t_rise, t_valid;
        exp_t e;
        apply_reset();
        queue_frame({8'h16, 1'b1}, '{valid: 1'b1, err: 1'b0, temp: 5'd22, ready: 1'b1});
        wait_cs(1'b0, ok_f, t_fall);
        wait_cs(1'b1, ok_r, t_rise);
        wait_output(seen);
        t_valid = cyc;
        total++;
        if (!(ok_f && ok_r && seen)) begin
            bad++;
            $display("FAIL good_timeout: cs_fall=%0b cs_rise=%0b output=%0b, want all 1", ok_f, ok_r, seen);
        end else begin
            e = exp_q.pop_front();
            total++;
            if ({temp_valid, temp_err, temperature, temp_ready} !== e) begin
                bad++;
                $display("FAIL good_value: got v=%b e=%b t=%0d r=%b, want v=%b e=%b t=%0d r=%b",
                         temp_valid, temp_err, temperature, temp_ready, e.valid, e.err, e.temp, e.ready);
            end
            total++;
            if (rises !== 4'd9) begin
                bad++;
                $display("FAIL good_sclk_rises: got %0d, want 9", rises);
            end
            total++;
            if ((t_rise - t_fall) != 19 * CLK_DIV) begin
                bad++;
                $display("FAIL good_cs_low_len: got %0d, want %0d", t_rise - t_fall, 19 * CLK_DIV);
            end
            total++;
            if ((t_valid - t_fall) != 1 + CLK_DIV + 18 * CLK_DIV) begin
                bad++;
                $display("FAIL good_conv_len: got %0d, want %0d", t_valid - t_fall, 1 + CLK_DIV + 18 * CLK_DIV);
            end
            @(negedge clk);
            total++;
            if ({temp_valid, temp_err} !== 2'b00) begin
                bad++;
                $display("FAIL good_pulse_width: got valid=%b err=%b, want 0 0", temp_valid, temp_err);
            end
        end
    endtask

    task automatic test_clamp();
        bit   seen;
        exp_t e;
        apply_reset();
        queue_frame({8'h2A, 1'b1}, '{valid: 1'b1, err: 1'b0, temp: 5'd31, ready: 1'b1});
        wait_output(seen);
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL clamp_timeout: no output, want one");
        end else begin
            e = exp_q.pop_front();
            total++;
            if ({temp_valid, temp_err, temperature, temp_ready} !== e) begin
                bad++;
                $display("FAIL clamp_value: got v=%b e=%b t=%0d r=%b, want v=%b e=%b t=%0d r=%b",
                         temp_valid, temp_err, temperature, temp_ready, e.valid, e.err, e.temp, e.ready);
            end
        end
    endtask

    task automatic test_parity();
        bit         seen;
        exp_t       e;
        logic [8:0] frames [2];
        exp_t       exps   [2];
        frames[0] = {8'h16, 1'b1};
        frames[1] = {8'h10, 1'b0};
        exps[0]   = '{valid: 1'b1, err: 1'b0, temp: 5'd22, ready: 1'b1};
        exps[1]   = '{valid: 1'b0, err: 1'b1, temp: 5'd22, ready: 1'b1};
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            queue_frame(frames[i], exps[i]);
            wait_output(seen);
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL parity_timeout[%0d]: no output, want one", i);
            end else begin
                e = exp_q.pop_front();
                total++;
                if ({temp_valid, temp_err, temperature, temp_ready} !== e) begin
                    bad++;
                    $display("FAIL parity_value[%0d]: got v=%b e=%b t=%0d r=%b, want v=%b e=%b t=%0d r=%b",
                             i, temp_valid, temp_err, temperature, temp_ready, e.valid, e.err, e.temp, e.ready);
                end
                @(negedge clk);
                total++;
                if ({temp_valid, temp_err} !== 2'b00) begin
                    bad++;
                    $display("FAIL parity_pulse_width[%0d]: got valid=%b err=%b, want 0 0", i, temp_valid, temp_err);
                end
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        bit   seen, hit;
        exp_t e;
        apply_reset();
        queue_frame({8'h16, 1'b1}, '{valid: 1'b1, err: 1'b0, temp: 5'd22, ready: 1'b1});
        wait_output(seen);
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL midrst_prime_timeout: no output, want one");
        end else begin
            e = exp_q.pop_front();
            total++;
            if ({temp_valid, temp_err, temperature, temp_ready} !== e) begin
                bad++;
                $display("FAIL midrst_prime_value: got t=%0d r=%b, want t=%0d r=%b",
                         temperature, temp_ready, e.temp, e.ready);
            end
        end
        queue_frame({8'h1F, 1'b1}, '{valid: 1'b1, err: 1'b0, temp: 5'd31, ready: 1'b1});
        hit = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (!sensor_cs_n && rises == 4'd4) begin
                hit = 1'b1;
                break;
            end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL midrst_reach_4_rises: not reached, want 4 rises");
        end
        rst = 1'b0;
        #1;
        total++;
        if ({sensor_cs_n, sensor_sclk, temperature, temp_valid, temp_ready, temp_err} !== 10'b10_00000_000) begin
            bad++;
            $display("FAIL midrst_async_values: got cs_n=%b sclk=%b temp=%0d valid=%b ready=%b err=%b, want 1 0 0 0 0 0",
                     sensor_cs_n, sensor_sclk, temperature, temp_valid, temp_ready, temp_err);
        end
        repeat (2) @(negedge clk);
        exp_q.delete();
        queue_frame({8'h05, 1'b0}, '{valid: 1'b1, err: 1'b0, temp: 5'd5, ready: 1'b1});
        rst = 1'b1;
        wait_output(seen);
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL midrst_after_timeout: no output, want one");
        end else begin
            e = exp_q.pop_front();
            total++;
            if ({temp_valid, temp_err, temperature, temp_ready} !== e) begin
                bad++;
                $display("FAIL midrst_after_value: got v=%b e=%b t=%0d r=%b, want v=%b e=%b t=%0d r=%b",
                         temp_valid, temp_err, temperature, temp_ready, e.valid, e.err, e.temp, e.ready);
            end
            total++;
            if (rises !== 4'd9) begin
                bad++;
                $display("FAIL midrst_after_rises: got %0d, want 9", rises);
            end
        end
    endtask

    task automatic test_average();
        bit         seen;
        exp_t       e;
        logic [7:0] raw;
        logic [7:0] raws [4];
        logic [4:0] outs [4];
        raws = '{8'd20, 8'd20, 8'd24, 8'd28};
`ifdef TEMP_AVG_EN
        outs = '{5'd20, 5'd20, 5'd21, 5'd23};
`else
        outs = '{5'd20, 5'd20, 5'd24, 5'd28};
`endif
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            raw = raws[i];
            queue_frame({raw, ^raw}, '{valid: 1'b1, err: 1'b0, temp: outs[i], ready: 1'b1});
            wait_output(seen);
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL avg_timeout[%0d]: no output, want one", i);
            end else begin
                e = exp_q.pop_front();
                total++;
                if ({temp_valid, temp_err, temperature, temp_ready} !== e) begin
                    bad++;
                    $display("FAIL avg_value[%0d]: got v=%b e=%b t=%0d r=%b, want v=%b e=%b t=%0d r=%b",
                             i, temp_valid, temp_err, temperature, temp_ready, e.valid, e.err, e.temp, e.ready);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_clamp();
        test_parity();
        test_reset_mid_shift();
        test_average();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/temp_sensor_if.md
# temp_sensor_if

Serial front-end for the home temperature sensor. It drives the sensor's chip-select and serial clock, shifts in a parity-protected 8-bit reading on a fixed sampling period, and clamps the reading to 0..31 °C. It presents the result on the 5-bit `temperature` bus that the AC controller consumes. Sits directly upstream of the AC block inside the smart-home top level.

## Interface
Parameters:
- `CLK_DIV`, default 4: sclk half-period in `clk` cycles; ≥1.
- `SAMPLE_PERIOD`, default 1000: `clk` cycles between conversion start ticks; must exceed 19*`CLK_DIV`+2.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `sensor_sdo`  in  1  serial data from the sensor, MSB first.
- `sensor_cs_n`  out  1  sensor chip-select, active low.
- `sensor_sclk`  out  1  sensor serial clock, idle low.
- `temperature`  out  5  clamped (optionally averaged) temperature, °C.
- `temp_valid`  out  1  one-cycle pulse when `temperature` updates.
- `temp_ready`  out  1  set after the first good sample; sticky until reset.
- `temp_err`  out  1  one-cycle pulse on a parity failure.

## Operation
- Period counter: 0..`SAMPLE_PERIOD`-1, free-running and wrapping. A start tick occurs when count == `SAMPLE_PERIOD`-1.
- FSM states and transitions:
  - IDLE: cs_n=1, sclk=0. Start tick → SETUP.
  - SETUP: cs_n=0 for `CLK_DIV` cycles → SHIFT.
  - SHIFT: sclk toggles every `CLK_DIV` cycles, for 9 full sclk periods.
    - `sensor_sdo` is sampled in the `clk` cycle where sclk rises 0→1.
    - Bits 0..7 form raw[7:0], MSB first. Bit 8 is the parity bit.
    - After the 9th falling edge → DONE.
  - DONE: cs_n=1 for one cycle, evaluate the frame → IDLE.
- Frame check: the total number of ones across all 9 bits must be even.
  - Good frame: value = (raw > 31) ? 31 : raw[4:0]. Update the output and pulse `temp_valid`. Set `temp_ready`.
  - Bad frame: `temperature` holds, `temp_err` pulses, `temp_ready` is unchanged.
- A start tick arriving while not in IDLE is dropped. The counter still wraps.

## Timing
- Reset values: `sensor_cs_n`=1, `sensor_sclk`=0, `temperature`=0, `temp_valid`=0, `temp_ready`=0, `temp_err`=0. FSM=IDLE, counter=0, history=0.
- Reset asserted mid-conversion aborts the conversion immediately. cs_n goes high asynchronously. No partial result is published.
- First start tick occurs `SAMPLE_PERIOD` cycles after reset release.
- Conversion length, from the start tick to the DONE cycle: 1 + `CLK_DIV` + 18*`CLK_DIV` cycles.
- `temperature`, `temp_valid`, `temp_ready` and `temp_err` are all registered. They change on the clock edge that ends DONE.
- `temp_valid` and `temp_err` are never high together and are never high for more than one cycle.

## Configuration
- `TEMP_AVG_EN` defined:
  - A 4-entry history of clamped values.
  - Output = (sum of the 4 entries) >> 2, truncating. The sum is 7 bits.
  - The first good sample after reset loads all four entries.
  - Each later good sample shifts in and evicts the oldest entry.
  - Bad frames do not touch the history.
- `TEMP_AVG_EN` undefined: output = latest clamped value. No history storage is built.

## Test plan
All scenarios use `CLK_DIV`=2, `SAMPLE_PERIOD`=64, and a sensor model that shifts on sclk falling edges.
- Good frame: sensor sends 0x16 with parity bit 1 → exactly one `temp_valid` pulse, `temperature`=22, `temp_ready`=1. sclk shows 9 rising edges while cs_n is low. Check the conversion length against the formula.
- Clamp: sensor sends 0x2A with parity 1 → `temperature`=31.
- Parity error:
  - Sensor sends 0x16 with parity 1 → `temperature`=22.
  - Next, sensor sends 0x10 with parity 0 → `temp_err` pulses once, no `temp_valid`, `temperature` stays 22.
- Reset mid-shift: assert `rst` low after 4 sclk rising edges → cs_n=1 and all outputs return to reset values at once. After release, the first valid sample is a complete new frame.
- Averaging (`TEMP_AVG_EN` defined): good samples 20, 20, 24, 28 → outputs 20, 20, 21, 23. With the macro undefined → outputs 20, 20, 24, 28.
